// File: rtl/regfile_pkg.sv
// Shared widths and the write-request record for the register-file write side.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// In-order write-request queue; exposes every slot's address and valid bit
// so the owner can detect pending writes without draining the queue.
module regfile_wr_fifo
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  wr_req_t                 push_req,
  input  logic                    pop,
  output wr_req_t                 head,
  output logic                    full,
  output logic                    empty,
  output logic [CNT_W-1:0]        count,
  output logic [DEPTH*ADDR_W-1:0] entry_addr,
  output logic [DEPTH-1:0]        entry_valid
);

  wr_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents of empty slots are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    entry_addr  = '0;
    entry_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_addr[i*ADDR_W +: ADDR_W] = mem[i].addr;
      entry_valid[i] = (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count);
    end
  end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32x32 register file: queued writeback requests commit
// one per cycle into the storage registers, which are exported flat.
module regfile_write_port #(
  parameter  int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter  int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter  int unsigned DEPTH    = 2,
  localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       WrValid,
  output logic                       WrReady,
  input  logic [ADDR_W-1:0]          WrAddr,
  input  logic [DATA_W-1:0]          WrData,
  input  logic                       Hold,
  input  logic [ADDR_W-1:0]          QueryAddr,
  output logic                       QueryPending,
  output logic                       Busy,
  output logic [NUM_REGS*DATA_W-1:0] Regs
);

  import regfile_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Register 0 reads as zero, so only registers 1..NUM_REGS-1 are stored.
  logic [DATA_W-1:0]       regs_q [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]     we;
  wr_req_t                 push_req;
  wr_req_t                 head;
  logic                    full;
  logic                    empty;
  logic                    commit;
  logic [CNT_W-1:0]        count;
  logic [DEPTH*ADDR_W-1:0] entry_addr;
  logic [DEPTH-1:0]        entry_valid;

  assign push_req = '{addr: WrAddr, data: WrData};
  assign commit   = !empty && !Hold;
  assign WrReady  = !full;
  assign Busy     = (count != '0);

  regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (Clk),
    .reset       (Reset),
    .push        (WrValid),
    .push_req    (push_req),
    .pop         (commit),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid)
  );

  // Decode the committing head entry into per-register write enables.
  always_comb begin
    we = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      we[i] = commit && (head.addr == ADDR_W'(i));
    end
  end

  // Storage registers; reset clears everything already committed.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (we[i]) regs_q[i] <= head.data;
      end
    end
  end

  // Flatten for the read mux; slot 0 is tied to zero.
  always_comb begin
    Regs = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      Regs[DATA_W*i +: DATA_W] = regs_q[i];
    end
  end

  // Hazard flag: any live queued write to the queried register.
  always_comb begin
    QueryPending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i*ADDR_W +: ADDR_W] == QueryAddr)) begin
        QueryPending = 1'b1;
      end
    end
    if (QueryAddr == ADDR_W'(ZERO_REG)) QueryPending = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port with hand-computed expectations.
module tb_regfile_write_port;

  logic          Clk;
  logic          Reset;
  logic          WrValid;
  logic          WrReady;
  logic [4:0]    WrAddr;
  logic [31:0]   WrData;
  logic          Hold;
  logic [4:0]    QueryAddr;
  logic          QueryPending;
  logic          Busy;
  logic [1023:0] Regs;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  regfile_write_port #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .WrValid      (WrValid),
    .WrReady      (WrReady),
    .WrAddr       (WrAddr),
    .WrData       (WrData),
    .Hold         (Hold),
    .QueryAddr    (QueryAddr),
    .QueryPending (QueryPending),
    .Busy         (Busy),
    .Regs         (Regs)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] rd(input int unsigned i);
    return Regs[32*i +: 32];
  endfunction

  function automatic int unsigned nonzero_regs();
    int unsigned n = 0;
    for (int unsigned i = 0; i < 32; i++) if (Regs[32*i +: 32] != 32'h0) n++;
    return n;
  endfunction

  // Advance one rising edge; inputs change and outputs are sampled at negedge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; WrValid = 1'b0; WrAddr = '0; WrData = '0; Hold = 1'b0; QueryAddr = '0;
    @(negedge Clk);
    step();
    Reset = 1'b0;
    check("rst_regs", 64'(nonzero_regs()), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_qp", 64'(QueryPending), 64'd0);
    check("rst_ready", 64'(WrReady), 64'd1);

    // Single write to r5.
    WrValid = 1'b1; WrAddr = 5'd5; WrData = 32'hDEADBEEF;
    step();
    WrValid = 1'b0;
    check("t1_busy", 64'(Busy), 64'd1);
    check("t1_nopass", 64'(rd(5)), 64'd0);
    step();
    check("t1_busy_clr", 64'(Busy), 64'd0);
    check("t1_r5", 64'(rd(5)), 64'hDEADBEEF);
    check("t1_others", 64'(nonzero_regs()), 64'd1);

    // Two held writes to r3, then release.
    Hold = 1'b1; WrValid = 1'b1; WrAddr = 5'd3; WrData = 32'h11;
    step();
    check("t2_ready1", 64'(WrReady), 64'd1);
    WrData = 32'h22;
    step();
    WrValid = 1'b0;
    check("t2_full", 64'(WrReady), 64'd0);
    QueryAddr = 5'd3; #1;
    check("t2_qp3", 64'(QueryPending), 64'd1);
    QueryAddr = 5'd4; #1;
    check("t2_qp4", 64'(QueryPending), 64'd0);
    QueryAddr = 5'd3;
    Hold = 1'b0;
    step();
    check("t2_r3_first", 64'(rd(3)), 64'h11);
    check("t2_qp_mid", 64'(QueryPending), 64'd1);
    check("t2_ready2", 64'(WrReady), 64'd1);
    step();
    check("t2_r3_last", 64'(rd(3)), 64'h22);
    check("t2_qp_done", 64'(QueryPending), 64'd0);
    check("t2_idle", 64'(Busy), 64'd0);

    // Write to r0 is consumed without effect.
    WrValid = 1'b1; WrAddr = 5'd0; WrData = 32'hFFFFFFFF; QueryAddr = 5'd0;
    step();
    WrValid = 1'b0;
    check("t3_busy", 64'(Busy), 64'd1);
    check("t3_qp0", 64'(QueryPending), 64'd0);
    step();
    check("t3_done", 64'(Busy), 64'd0);
    check("t3_r0", 64'(rd(0)), 64'd0);
    check("t3_r3", 64'(rd(3)), 64'h22);
    check("t3_r5", 64'(rd(5)), 64'hDEADBEEF);

    // Streaming writes to r1..r8 with no back-pressure.
    for (int unsigned k = 1; k <= 8; k++) begin
      WrValid = 1'b1; WrAddr = 5'(k); WrData = 32'hA000_0000 | k;
      check($sformatf("t4_ready%0d", k), 64'(WrReady), 64'd1);
      step();
      if (k > 1) check($sformatf("t4_r%0d", k - 1), 64'(rd(k - 1)), 64'(32'hA000_0000 | (k - 1)));
    end
    WrValid = 1'b0;
    step();
    check("t4_busy", 64'(Busy), 64'd0);
    for (int unsigned k = 1; k <= 8; k++)
      check($sformatf("t4_final_r%0d", k), 64'(rd(k)), 64'(32'hA000_0000 | k));

    // Reset with a full queue and a presented request.
    Hold = 1'b1; WrValid = 1'b1; WrAddr = 5'd10; WrData = 32'h1010;
    step();
    WrAddr = 5'd11; WrData = 32'h1111;
    step();
    check("t5_full", 64'(WrReady), 64'd0);
    WrAddr = 5'd12; WrData = 32'h1212; Reset = 1'b1;
    step();
    Reset = 1'b0; WrValid = 1'b0; Hold = 1'b0;
    check("t5_regs", 64'(nonzero_regs()), 64'd0);
    check("t5_busy", 64'(Busy), 64'd0);
    check("t5_ready", 64'(WrReady), 64'd1);
    step();
    step();
    check("t5_regs_later", 64'(nonzero_regs()), 64'd0);

    // Drain a full queue while the sender keeps requesting.
    Hold = 1'b1; WrValid = 1'b1; WrAddr = 5'd20; WrData = 32'h20;
    step();
    WrAddr = 5'd21; WrData = 32'h21;
    step();
    WrAddr = 5'd22; WrData = 32'h2222; Hold = 1'b0;
    check("t6_ready_drain", 64'(WrReady), 64'd0);
    step();
    check("t6_ready_next", 64'(WrReady), 64'd1);
    check("t6_r20", 64'(rd(20)), 64'h20);
    check("t6_r22_none", 64'(rd(22)), 64'd0);
    step();
    check("t6_r21", 64'(rd(21)), 64'h21);
    WrData = 32'h3333;
    step();
    WrValid = 1'b0;
    check("t6_r22_a", 64'(rd(22)), 64'h2222);
    step();
    check("t6_r22_b", 64'(rd(22)), 64'h3333);
    check("t6_idle", 64'(Busy), 64'd0);
    step();
    check("t6_r22_hold", 64'(rd(22)), 64'h3333);
    check("t6_count", 64'(nonzero_regs()), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the 32x32 register file.
- Accepts writeback requests from the multicycle control path over a valid/ready handshake and buffers them in a small in-order queue.
- Commits one request per cycle into 32 storage registers.
- Exposes all 32 registers as a flat bus that feeds the existing 32-input read mux (In0..In31), plus a pending-write hazard flag for the controller.

Parameters:
DATA_W, 32, width of each register and of the write data
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W = 32
DEPTH, 2, write-queue entries (power of two, >= 2)

Ports:
Clk  input  1  single clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
WrValid  input  1  write request valid
WrReady  output  1  queue can accept a request this cycle
WrAddr  input  ADDR_W  destination register
WrData  input  DATA_W  data to write
Hold  input  1  when high, the queue head is not committed this cycle
QueryAddr  input  ADDR_W  register the controller is about to read
QueryPending  output  1  a queued, uncommitted write targets QueryAddr
Busy  output  1  queue non-empty
Regs  output  NUM_REGS*DATA_W  Regs[DATA_W*i +: DATA_W] = register i

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high. At an edge with Reset=1:
  - all registers clear to 0;
  - queue empties (count=0, pointers=0);
  - any request presented in the same cycle is dropped.
- Reset asserted mid-operation discards every queued write. Registers already committed are cleared too.
- Output values out of reset: Regs=0, Busy=0, QueryPending=0, WrReady=1.
- Accept: a request is taken at an edge where WrValid=1 and WrReady=1.
  - WrReady = (count < DEPTH). It depends on count only; there is no combinational path from WrValid or Hold.
  - WrValid with WrReady=0 is ignored. The sender must hold its request until accepted.
- Commit: at each edge where count>0 and Hold=0, the head entry is written to register[addr] and popped.
  - Minimum latency: accepted at edge N, committed at edge N+1, visible on Regs after edge N+1.
  - No pass-through: a request never commits in the same edge it is accepted.
- Simultaneous accept and commit: count is unchanged. Both pointers advance modulo DEPTH (wrap-around).
- Full queue with Hold=0: the commit frees a slot, but WrReady stays 0 for that cycle. WrReady rises the next cycle.
- Hold=1: no commit; the queue may fill to DEPTH.
- Register 0:
  - a write to address 0 is accepted and consumes a commit slot but changes nothing;
  - Regs[DATA_W-1:0] is constant 0 at all times.
- Ordering: commits occur strictly in acceptance order. Multiple queued writes to one address apply in order, so the last one wins.
- QueryPending: combinational OR over valid queue entries of (entry.addr == QueryAddr). It is forced to 0 when QueryAddr == 0.
- Busy = (count != 0).
- Widths: count is ceil(log2(DEPTH+1)) bits. Pointers are log2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package (regfile_pkg) holds:
  - DATA_W, ADDR_W, NUM_REGS, ZERO_REG=0;
  - the write-request record type {addr, data}.
- One sub-module, regfile_wr_fifo:
  - a generic DEPTH-entry synchronous FIFO with push/pop, full/empty, and count;
  - exposes all entry addresses plus valid bits for the QueryPending compare.
- The top level holds the register array, decode and write-enable logic, and the Regs flattening.

Test Plan:
- Reset, then WrValid with WrAddr=5, WrData=0xDEADBEEF for one cycle, Hold=0:
  - Busy=1 for one cycle;
  - register 5 reads 0xDEADBEEF after the next edge;
  - all other registers stay 0.
- Hold=1, push addr 3 (0x11) then addr 3 (0x22):
  - WrReady=0 after the second accept;
  - QueryAddr=3 gives QueryPending=1;
  - release Hold: register 3 = 0x11, then 0x22 one edge later;
  - QueryPending returns to 0.
- Write addr 0 with 0xFFFFFFFF:
  - accepted and committed;
  - Regs[31:0] stays 0;
  - QueryAddr=0 always gives QueryPending=0.
- Continuous WrValid for 8 cycles, addrs 1..8, Hold=0:
  - WrReady stays 1 throughout;
  - count never exceeds 1;
  - registers 1..8 hold their data in order;
  - pointers wrap at least twice.
- Fill the queue (Hold=1), then assert Reset for one cycle with WrValid=1:
  - all registers 0, Busy=0, WrReady=1;
  - the queued and presented writes never appear.
- Full queue, drop Hold, and drive WrValid every cycle:
  - WrReady is 0 on the first drain cycle and 1 on the next;
  - no request is lost or duplicated.
